// File: rtl/pot_manager.sv
// Table pot: collects committed bets, tracks round contributions,
// and splits the pot evenly among winners as serial payout pulses.
module pot_manager #(
  parameter int NUM_PLAYERS = 4,
  parameter int MAX_STACK_W = 10,
  parameter int POT_W       = 12,
  localparam int PID_W      = $clog2(NUM_PLAYERS)
) (
  input  logic                         clk,
  input  logic                         pot_reset,
  input  logic                         round_start,
  input  logic                         bet_valid,
  output logic                         bet_ready,
  input  logic [PID_W-1:0]             bet_player,
  input  logic [MAX_STACK_W-1:0]       bet_value,
  output logic                         bet_error,
  input  logic                         award_req,
  input  logic [NUM_PLAYERS-1:0]       winner_mask,
  output logic                         award_error,
  output logic [POT_W-1:0]             pot,
  output logic [POT_W-1:0]             highest_bet,
  output logic [NUM_PLAYERS*POT_W-1:0] round_bet,
  output logic                         payout_valid,
  output logic [PID_W-1:0]             payout_player,
  output logic [POT_W-1:0]             payout_amount,
  output logic                         payout_done,
  output logic                         busy
);

  localparam int KW = $clog2(NUM_PLAYERS + 1);
  localparam int CW = $clog2(POT_W);

  typedef enum logic [1:0] {COLLECT, DIVIDE, PAYOUT} state_e;

  state_e               state_q, state_d;
  logic [POT_W-1:0]     pot_q, pot_d;
  logic [POT_W-1:0]     hb_q, hb_d;
  logic [POT_W-1:0]     rb_q [NUM_PLAYERS];
  logic [POT_W-1:0]     rb_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] mask_q, mask_d;
  logic [KW-1:0]        k_q, k_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [POT_W-1:0]     quo_q, quo_d;
  logic [KW-1:0]        rem_q, rem_d;
  logic [PID_W-1:0]     idx_q, idx_d;
  logic                 first_q, first_d;
  logic                 berr_q, berr_d;
  logic                 aerr_q, aerr_d;
  logic                 done_q, done_d;

  logic             fire, accept;
  logic             award_ok, award_bad;
  logic             last_seat;
  logic [POT_W:0]   sum;
  logic [KW:0]      trial;
  logic             ge;

  assign fire      = bet_valid && bet_ready;
  assign sum       = {1'b0, pot_q} + (POT_W+1)'(bet_value);
  assign accept    = fire && !sum[POT_W]
                     && (int'(bet_player) < NUM_PLAYERS);
  assign award_ok  = (state_q == COLLECT) && award_req
                     && (|winner_mask);
  assign award_bad = (state_q == COLLECT) && award_req
                     && !(|winner_mask);
  assign last_seat = idx_q == PID_W'(NUM_PLAYERS - 1);
  // restoring division step: shift in the next dividend bit
  assign trial     = {rem_q, pot_q[cnt_q]};
  assign ge        = trial >= {1'b0, k_q};

  always_ff @(posedge clk) begin
    if (pot_reset) state_q <= COLLECT;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (award_ok) state_d = DIVIDE;
      DIVIDE:  if (cnt_q == '0) state_d = PAYOUT;
      PAYOUT:  if (last_seat) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    bet_ready     = (state_q == COLLECT) && !award_req;
    busy          = state_q != COLLECT;
    payout_valid  = (state_q == PAYOUT) && mask_q[idx_q];
    payout_player = payout_valid ? idx_q : '0;
    payout_amount = '0;
    if (payout_valid)
      payout_amount = quo_q + (first_q ? POT_W'(rem_q) : '0);
  end

  always_comb begin
    pot_d   = pot_q;
    hb_d    = hb_q;
    rb_d    = rb_q;
    mask_d  = mask_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    first_d = first_q;
    berr_d  = fire && !accept;
    aerr_d  = award_bad;
    done_d  = (state_q == PAYOUT) && last_seat;
    unique case (state_q)
      COLLECT: begin
        if (round_start) begin
          for (int i = 0; i < NUM_PLAYERS; i++) rb_d[i] = '0;
          hb_d = '0;
        end
        if (accept) begin
          pot_d = sum[POT_W-1:0];
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (bet_player == PID_W'(i)) begin
              rb_d[i] = rb_d[i] + POT_W'(bet_value);
              if (rb_d[i] > hb_d) hb_d = rb_d[i];
            end
          end
        end
        if (award_ok) begin
          mask_d = winner_mask;
          k_d    = KW'($countones(winner_mask));
          cnt_d  = CW'(POT_W - 1);
          quo_d  = '0;
          rem_d  = '0;
        end
      end
      DIVIDE: begin
        rem_d        = ge ? KW'(trial - {1'b0, k_q}) : trial[KW-1:0];
        quo_d[cnt_q] = ge;
        cnt_d        = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          idx_d   = '0;
          first_d = 1'b1;
        end
      end
      PAYOUT: begin
        if (mask_q[idx_q]) first_d = 1'b0;
        idx_d = idx_q + 1'b1;
        if (last_seat) begin
          pot_d = '0;
          hb_d  = '0;
          for (int i = 0; i < NUM_PLAYERS; i++) rb_d[i] = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (pot_reset) begin
      pot_q   <= '0;
      hb_q    <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) rb_q[i] <= '0;
      mask_q  <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      first_q <= 1'b0;
      berr_q  <= 1'b0;
      aerr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pot_q   <= pot_d;
      hb_q    <= hb_d;
      rb_q    <= rb_d;
      mask_q  <= mask_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      berr_q  <= berr_d;
      aerr_q  <= aerr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++)
      round_bet[i*POT_W +: POT_W] = rb_q[i];
  end

  assign pot         = pot_q;
  assign highest_bet = hb_q;
  assign bet_error   = berr_q;
  assign award_error = aerr_q;
  assign payout_done = done_q;

endmodule
